microwave_timer: RTL
====================

# microwave_timer

Countdown timer for the microwave controller, and the counterpart of `magnetron_control`. It takes the cook time from the keypad as four BCD digits (MM:SS) and counts down one second per prescaled period while the magnetron is on. It drives `timer_done` back to `magnetron_control` and exports the digits to the display. It consumes `magnetron_control`'s `Q` as its run enable and produces the `timer_done` that block consumes.

## Interface

**Parameters**

- `TICKS_PER_SEC`, default 1000000: `clk` cycles per counted second (1 MHz clock). Must be ≥ 2. Benches use 4.
- `PRE_W`, default 20: prescaler width. Must satisfy 2^`PRE_W` ≥ `TICKS_PER_SEC`.

**Ports**

- `clk` input 1: single system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: run enable, connected to `magnetron_control.Q`. 1 = count down.
- `clearn` input 1: active-low clear button, synchronous.
- `key_valid` input 1: one-cycle strobe marking a keypad digit.
- `key_digit` input 4: BCD digit qualified by `key_valid`.
- `min_tens` output 4: minutes tens digit.
- `min_ones` output 4: minutes ones digit.
- `sec_tens` output 4: seconds tens digit.
- `sec_ones` output 4: seconds ones digit.
- `timer_done` output 1: 1 when all four digits are 0.
- `running` output 1: 1 while `en`=1 and the count is nonzero.

## Operation

**Reset.** On `rst`=1 at a clock edge:

- All digits become 0 and the prescaler becomes 0.
- `timer_done`=1 and `running`=0.

**Per-edge priority** (first matching row wins):

1. `rst`
2. `clearn`=0: digits := 0, prescaler := 0.
3. `key_valid`=1 and `en`=0 and `key_digit`≤9: digit shift entry.
4. `en`=1 and count≠0: prescaler and countdown.
5. Otherwise: hold.

**Digit entry.** The digits shift left one place:

- `min_tens` := `min_ones`
- `min_ones` := `sec_tens`
- `sec_tens` := `sec_ones`
- `sec_ones` := `key_digit`
- The old `min_tens` is discarded.

A `key_digit` of 10–15 is ignored (no change). A `key_valid` while `en`=1 is ignored, so entry is locked while cooking.

**Prescaler.** While row 4 applies, the prescaler increments each cycle. When it equals `TICKS_PER_SEC`-1, it wraps to 0 and the count decrements by one second in the same edge.

**Prescaler hold.** When `en` drops (pause via stopn or door opened upstream), the prescaler keeps its value, so a resumed run finishes the partial second.

**Decrement** (BCD with borrow):

- `sec_ones`≠0: `sec_ones`-1.
- Else `sec_ones` := 9, and:
  - `sec_tens`≠0: `sec_tens`-1.
  - Else `sec_tens` := 5, and:
    - `min_ones`≠0: `min_ones`-1.
    - Else `min_ones` := 9 and `min_tens`-1.
- Decrement is never applied at 00:00.

**Entered seconds above 59.** Seconds tens digits above 5 (e.g. 0:75) are legal. They count down normally: 75, 74, …, 60, 59, …

**Outputs.**

- `timer_done` = (all digits == 0). It is a combinational decode of the registers, with no added latency.
- `running` = `en` & ~`timer_done`.
- Once the count reaches 00:00 the prescaler holds and the count stays 00:00 until new entry. `magnetron_control` then drops `Q`.

**Derived states** (no separate state register needed):

- ZERO: count==0.
- SET: count≠0, `en`=0.
- RUN: count≠0, `en`=1.
- Transitions:
  - ZERO→SET on the first nonzero key.
  - SET→RUN on `en` rising.
  - RUN→SET on `en` falling.
  - RUN→ZERO on the last decrement.
  - Any state→ZERO on `clearn`=0 or `rst`.

## Timing

- Every register updates only on the `clk` rising edge. There is no asynchronous path.
- Key entry is visible on the digit outputs the cycle after the `key_valid` edge.
- With the prescaler at 0, the first decrement happens on the `TICKS_PER_SEC`-th rising edge with `en`=1. Each later decrement follows every `TICKS_PER_SEC` enabled edges.
- An N-second count with an uninterrupted `en` reaches 0 after N·`TICKS_PER_SEC` edges. `timer_done` rises in the same cycle the digits read 0000.
- `clearn`=0 takes effect at the next edge even when `en`=1. `timer_done`=1 the cycle after.
- `rst` mid-count behaves the same as `clearn` and also overrides simultaneous `key_valid`.
- `clearn` and `key_valid` asserted together: the clear wins and the key is lost.

## Test plan

All scenarios use `TICKS_PER_SEC`=4.

1. **Reset.** Hold `rst` 2 cycles → digits 0000, `timer_done`=1, `running`=0. Key 1 then 2 → display 00:12, `timer_done`=0.
2. **Countdown and borrow.** Enter 1,0,0 (01:00) and hold `en`=1.
   - After 4 edges → 00:59; after 8 → 00:58.
   - After 240 edges → 00:00 and `timer_done`=1.
   - Further edges keep 00:00.
3. **Pause and resume.** Enter 5 and hold `en`=1 for 6 edges → 00:04 with prescaler 2. Drop `en` for 10 cycles → no change. Raise `en` → 00:03 after 2 more edges.
4. **Clear.** Enter 3,0 and run 3 edges. Pulse `clearn`=0 for 1 cycle → 00:00, `timer_done`=1 next cycle. Re-enter 2 and run → the first decrement takes 4 edges (prescaler was cleared).
5. **Entry rules.** Enter 9,9,9,9,8 → 99:98 (oldest digit dropped). With `en`=1, send key 7 → no change. With `en`=0, send `key_digit`=12 → no change.
6. **Reset mid-run.** Enter 4,5 and run with `en`=1. Assert `rst` together with `key_valid`/`key_digit`=3 → 00:00, `running`=0, key ignored.

Source files
------------

// File: rtl/microwave_timer.sv
// microwave_timer: MM:SS BCD countdown with keypad shift entry and a per-second prescaler.
module microwave_timer #(
  parameter int TICKS_PER_SEC = 1000000,
  parameter int PRE_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       running
);
  logic [3:0] mt_q, mo_q, st_q, so_q, mt_d, mo_d, st_d, so_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic zero, tick, b_st, b_mo;
  always_comb begin
    zero = {mt_q, mo_q, st_q, so_q} == 16'd0;
    tick = pre_q == PRE_W'(TICKS_PER_SEC - 1);
    b_st = so_q == 4'd0;
    b_mo = b_st && st_q == 4'd0;
    mt_d = mt_q;
    mo_d = mo_q;
    st_d = st_q;
    so_d = so_q;
    pre_d = pre_q;
    if (!clearn) begin
      {mt_d, mo_d, st_d, so_d} = 16'd0;
      pre_d = '0;
    end else if (key_valid && !en && key_digit <= 4'd9) begin
      {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, key_digit};
    end else if (en && !zero) begin
      // prescaler is left untouched whenever en is low so a paused second resumes where it stopped
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      if (tick) begin
        so_d = b_st ? 4'd9 : so_q - 4'd1;
        st_d = b_st ? (st_q == 4'd0 ? 4'd5 : st_q - 4'd1) : st_q;
        mo_d = b_mo ? (mo_q == 4'd0 ? 4'd9 : mo_q - 4'd1) : mo_q;
        mt_d = (b_mo && mo_q == 4'd0) ? mt_q - 4'd1 : mt_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {mt_q, mo_q, st_q, so_q} <= 16'd0;
      pre_q <= '0;
    end else begin
      {mt_q, mo_q, st_q, so_q} <= {mt_d, mo_d, st_d, so_d};
      pre_q <= pre_d;
    end
  end
  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign timer_done = zero;
  assign running = en & ~zero;
endmodule
